countdown_timer: RTL and testbench

- Loadable down-counter, the complement of the existing up-counter (`incr` / `count_reg` style).
- Accepts a start value over a valid/ready load handshake and decrements on each `decr` strobe.
- Emits a one-cycle `done` pulse when the count reaches zero, then returns to idle.
- Used as a timeout/interval source alongside the up-counter in the counter/timer subsystem.

---
 rtl/counter_pkg.sv | 13 +
 rtl/countdown_timer_if.sv | 36 +++
 rtl/countdown_timer.sv | 65 ++++++
 tb/tb_countdown_timer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter/timer subsystem.
// Used by the up-counter and the countdown timer.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIRE
    } cdt_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control strobes and status of the countdown timer.
// The master side requests loads; the slave side is the timer.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             decr;
    logic             abort;
    logic [WIDTH-1:0] count_reg;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output load_value,
        output decr,
        output abort,
        input  load_ready,
        input  count_reg,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  decr,
        input  abort,
        output load_ready,
        output count_reg,
        output busy,
        output done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse at terminal count.
// RUN is only entered with a non-zero count, so the decrement never wraps.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    countdown_timer_if.slave      tmr
);

    cdt_state_e       r_state;
    cdt_state_e       w_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (tmr.load_valid) begin
                    w_count_nxt = tmr.load_value;
                    w_next      = (tmr.load_value == '0) ? FIRE : RUN;
                end
            end
            RUN: begin
                // abort wins over a simultaneous decrement
                if (tmr.abort) begin
                    w_count_nxt = '0;
                    w_next      = IDLE;
                end else if (tmr.decr) begin
                    w_count_nxt = r_count - WIDTH'(1);
                    if (r_count == WIDTH'(1)) begin
                        w_next = FIRE;
                    end
                end
            end
            FIRE: begin
                w_next = IDLE;
            end
            default: begin
                w_next      = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign tmr.load_ready = (r_state == IDLE);
    assign tmr.busy       = (r_state == RUN);
    assign tmr.done       = (r_state == FIRE);
    assign tmr.count_reg  = r_count;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer.
// Inputs change and outputs are sampled on the falling edge.
module tb_countdown_timer;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    countdown_timer_if #(.WIDTH(8)) tif ();

    countdown_timer #(.WIDTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .tmr  (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if (tif.count_reg !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", tif.count_reg);
        end
        checks++;
        if ({tif.busy, tif.done, tif.load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/rdy=%b expected 001",
                     {tif.busy, tif.done, tif.load_ready});
        end
    endtask

    task automatic test_load_countdown();
        rstn           = 1'b1;
        tif.load_valid = 1'b1;
        tif.load_value = 8'd4;
        tif.decr       = 1'b1;
        tick();
        tif.load_valid = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd4 || tif.busy !== 1'b1 ||
            tif.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load4_accept: got cnt=%0d busy=%b rdy=%b expected 4 1 0",
                     tif.count_reg, tif.busy, tif.load_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (tif.count_reg !== 8'(4 - k) || tif.done !== (k == 4) ||
                tif.busy !== (k != 4)) begin
                errors++;
                $display("FAIL load4_step%0d: got cnt=%0d done=%b busy=%b expected %0d %b %b",
                         k, tif.count_reg, tif.done, tif.busy,
                         4 - k, k == 4, k != 4);
            end
        end
        tif.decr = 1'b0;
        tick();
        checks++;
        if (tif.done !== 1'b0 || tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load4_idle: got done=%b rdy=%b expected 0 1",
                     tif.done, tif.load_ready);
        end
    endtask

    task automatic test_gapped_decr();
        logic [7:0] exp_cnt [5];
        logic       pat     [5];
        exp_cnt = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
        pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tif.load_valid = 1'b1;
        tif.load_value = 8'd3;
        tick();
        tif.load_valid = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd3 || tif.busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_accept: got cnt=%0d busy=%b expected 3 1",
                     tif.count_reg, tif.busy);
        end
        for (int k = 0; k < 5; k++) begin
            tif.decr = pat[k];
            tick();
            checks++;
            if (tif.count_reg !== exp_cnt[k] || tif.busy !== (k != 4) ||
                tif.done !== (k == 4)) begin
                errors++;
                $display("FAIL gap_step%0d: got cnt=%0d busy=%b done=%b expected %0d %b %b",
                         k, tif.count_reg, tif.busy, tif.done,
                         exp_cnt[k], k != 4, k == 4);
            end
        end
        tif.decr = 1'b0;
        tick();
        checks++;
        if (tif.done !== 1'b0 || tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_idle: got done=%b rdy=%b expected 0 1",
                     tif.done, tif.load_ready);
        end
    endtask

    task automatic test_zero_load();
        tif.load_valid = 1'b1;
        tif.load_value = 8'd0;
        tick();
        tif.load_valid = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd0 || tif.busy !== 1'b0 ||
            tif.done !== 1'b1 || tif.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_fire: got cnt=%0d busy=%b done=%b rdy=%b expected 0 0 1 0",
                     tif.count_reg, tif.busy, tif.done, tif.load_ready);
        end
        tick();
        checks++;
        if (tif.busy !== 1'b0 || tif.done !== 1'b0 ||
            tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle: got busy=%b done=%b rdy=%b expected 0 0 1",
                     tif.busy, tif.done, tif.load_ready);
        end
    endtask

    task automatic test_abort();
        tif.load_valid = 1'b1;
        tif.load_value = 8'd5;
        tif.decr       = 1'b1;
        tick();
        checks++;
        if (tif.count_reg !== 8'd5) begin
            errors++;
            $display("FAIL abort_load: got %0d expected 5", tif.count_reg);
        end
        // reload attempt while running must be ignored
        tif.load_value = 8'd9;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (tif.count_reg !== 8'(5 - k) || tif.load_ready !== 1'b0) begin
                errors++;
                $display("FAIL abort_run%0d: got cnt=%0d rdy=%b expected %0d 0",
                         k, tif.count_reg, tif.load_ready, 5 - k);
            end
        end
        tif.load_valid = 1'b0;
        tif.abort      = 1'b1;
        tick();
        tif.abort = 1'b0;
        tif.decr  = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd0 || tif.busy !== 1'b0 ||
            tif.done !== 1'b0 || tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_hit: got cnt=%0d busy=%b done=%b rdy=%b expected 0 0 0 1",
                     tif.count_reg, tif.busy, tif.done, tif.load_ready);
        end
        tick();
        checks++;
        if (tif.done !== 1'b0 || tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_after: got done=%b rdy=%b expected 0 1",
                     tif.done, tif.load_ready);
        end
    endtask

    task automatic test_midrun_reset();
        tif.load_valid = 1'b1;
        tif.load_value = 8'd200;
        tick();
        tif.load_valid = 1'b0;
        tif.decr       = 1'b1;
        repeat (10) tick();
        checks++;
        if (tif.count_reg !== 8'd190) begin
            errors++;
            $display("FAIL rst_pre: got %0d expected 190", tif.count_reg);
        end
        rstn = 1'b0;
        tick();
        rstn     = 1'b1;
        tif.decr = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd0 || tif.busy !== 1'b0 ||
            tif.done !== 1'b0 || tif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got cnt=%0d busy=%b done=%b rdy=%b expected 0 0 0 1",
                     tif.count_reg, tif.busy, tif.done, tif.load_ready);
        end
        tick();
        checks++;
        if (tif.done !== 1'b0 || tif.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got done=%b busy=%b expected 0 0",
                     tif.done, tif.busy);
        end
    endtask

    task automatic test_back_to_back();
        tif.load_valid = 1'b1;
        tif.load_value = 8'd255;
        tif.decr       = 1'b1;
        tick();
        tif.load_valid = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd255 || tif.busy !== 1'b1) begin
            errors++;
            $display("FAIL full_load: got cnt=%0d busy=%b expected 255 1",
                     tif.count_reg, tif.busy);
        end
        for (int k = 1; k <= 255; k++) begin
            tick();
            checks++;
            if (tif.count_reg !== 8'(255 - k) || tif.done !== (k == 255)) begin
                errors++;
                $display("FAIL full_step%0d: got cnt=%0d done=%b expected %0d %b",
                         k, tif.count_reg, tif.done, 255 - k, k == 255);
            end
        end
        // request held through FIRE; accepted on the first IDLE edge
        tif.load_valid = 1'b1;
        tif.load_value = 8'd2;
        tick();
        checks++;
        if (tif.load_ready !== 1'b1 || tif.count_reg !== 8'd0 ||
            tif.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got rdy=%b cnt=%0d done=%b expected 1 0 0",
                     tif.load_ready, tif.count_reg, tif.done);
        end
        tick();
        tif.load_valid = 1'b0;
        checks++;
        if (tif.count_reg !== 8'd2 || tif.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load: got cnt=%0d busy=%b expected 2 1",
                     tif.count_reg, tif.busy);
        end
        tick();
        tick();
        checks++;
        if (tif.count_reg !== 8'd0 || tif.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got cnt=%0d done=%b expected 0 1",
                     tif.count_reg, tif.done);
        end
        tif.decr = 1'b0;
        tick();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rstn           = 1'b0;
        tif.load_valid = 1'b0;
        tif.load_value = 8'd0;
        tif.decr       = 1'b0;
        tif.abort      = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_countdown();
        test_gapped_decr();
        test_zero_load();
        test_abort();
        test_midrun_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
